// File: rtl/matrix_scan_pwm.sv
// RGB dot-matrix column scanner with per-pixel PWM and a prefetching shadow buffer.
// Define MATRIX_BRIGHTNESS_EN to add a global brightness input that scales duties on active load.

module matrix_scan_pwm_row #(
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lit,
  input  logic [PWM_BITS-1:0]   pwm_cnt,
  input  logic [3*PWM_BITS-1:0] duty,
  output logic [2:0]            rgb
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rgb <= '0;
    else if (!lit) rgb <= '0;
    else begin
      rgb[2] <= pwm_cnt < duty[3*PWM_BITS-1:2*PWM_BITS];
      rgb[1] <= pwm_cnt < duty[2*PWM_BITS-1:PWM_BITS];
      rgb[0] <= pwm_cnt < duty[PWM_BITS-1:0];
    end
  end
endmodule

module matrix_scan_pwm #(
  parameter int COLS         = 16,
  parameter int ROWS         = 8,
  parameter int PWM_BITS     = 8,
  parameter int COL_CYCLES   = 1875,
  parameter int BLANK_CYCLES = 375,
  parameter int ADDR_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef MATRIX_BRIGHTNESS_EN
  input  logic [PWM_BITS-1:0]   brightness,
`endif
  input  logic [3*PWM_BITS-1:0] mem_data,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [3*ROWS-1:0]     rgb,
  output logic [COLS-1:0]       anode,
  output logic                  frame_start
);
  localparam int PW   = 3*PWM_BITS;
  localparam int DISP = COL_CYCLES - BLANK_CYCLES;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW   = $clog2(COL_CYCLES);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           col, col_inc;
  logic [SW-1:0]           slot_cnt;
  logic [PWM_BITS-1:0]     pwm_cnt;
  logic [ROWS-1:0][PW-1:0] shadow, active, load_src, load_val;
  logic                    prime_end, slot_end, lit, cap;

  assign col_inc   = (col == CW'(COLS-1)) ? '0 : col + CW'(1);
  assign prime_end = (state == PRIME) && (slot_cnt == SW'(ROWS));
  assign slot_end  = (state == SCAN) && (slot_cnt == SW'(COL_CYCLES-1));
  assign lit       = enable && (state == SCAN) && (slot_cnt < SW'(DISP));
  assign cap       = (state != IDLE) && (slot_cnt != '0) && (slot_cnt <= SW'(ROWS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    case (state)
      IDLE: if (enable) state_nxt = PRIME;
      PRIME: begin
        if (slot_cnt < SW'(ROWS)) mem_addr = ADDR_W'(slot_cnt);
        if (!enable)        state_nxt = IDLE;
        else if (prime_end) state_nxt = SCAN;
      end
      SCAN: begin
        // Prefetch the next column while the current one is on display.
        if (slot_cnt < SW'(ROWS))
          mem_addr = ADDR_W'(int'(col_inc) * ROWS + int'(slot_cnt));
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The last prime word arrives on the same cycle active is loaded, so bypass it.
  always_comb begin
    load_src = shadow;
    if (state == PRIME) load_src[ROWS-1] = mem_data;
  end

`ifdef MATRIX_BRIGHTNESS_EN
  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] d,
                                                input logic [PWM_BITS-1:0] b);
    logic [2*PWM_BITS-1:0] prod;
    prod = (2*PWM_BITS)'(d) * ((2*PWM_BITS)'(b) + (2*PWM_BITS)'(1));
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction

  always_comb begin
    load_val = load_src;
    for (int r = 0; r < ROWS; r++)
      for (int ch = 0; ch < 3; ch++)
        load_val[r][ch*PWM_BITS +: PWM_BITS] = scale(load_src[r][ch*PWM_BITS +: PWM_BITS], brightness);
  end
`else
  assign load_val = load_src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col      <= '0;
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      shadow   <= '0;
      active   <= '0;
    end else begin
      if (enable && cap)
        for (int r = 0; r < ROWS; r++)
          if (slot_cnt == SW'(r+1)) shadow[r] <= mem_data;
      if (enable && (prime_end || slot_end)) active <= load_val;
      if (!enable || state == IDLE) begin
        col      <= '0;
        slot_cnt <= '0;
        pwm_cnt  <= '0;
      end else if (state == PRIME) begin
        slot_cnt <= prime_end ? '0 : slot_cnt + SW'(1);
      end else if (slot_end) begin
        slot_cnt <= '0;
        pwm_cnt  <= '0;
        col      <= col_inc;
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
        if (slot_cnt < SW'(DISP)) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode       <= '0;
      frame_start <= 1'b0;
    end else begin
      anode       <= lit ? (COLS'(1) << col) : '0;
      frame_start <= lit && (slot_cnt == '0) && (col == '0);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : gen_row
    matrix_scan_pwm_row #(.PWM_BITS(PWM_BITS)) u_row (
      .clk     (clk),
      .rst     (rst),
      .lit     (lit),
      .pwm_cnt (pwm_cnt),
      .duty    (active[r]),
      .rgb     (rgb[3*r +: 3])
    );
  end
endmodule

// File: tb/tb_matrix_scan_pwm.sv
// Randomized bench for matrix_scan_pwm against a slot/frame-level arithmetic model.
module tb_matrix_scan_pwm;
  localparam int COLS = 4, ROWS = 2, PB = 4, CC = 40, BLANK = 8, AW = 3;
  localparam int DISP = CC - BLANK;
  localparam int PW   = 3*PB;

  logic              clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [PW-1:0]     mem_data;
  logic [AW-1:0]     mem_addr;
  logic [3*ROWS-1:0] rgb;
  logic [COLS-1:0]   anode;
  logic              frame_start;
  int                bright = 15;
  logic [PW-1:0]     ram [COLS*ROWS];
  int                checks = 0, errors = 0;

  bit mrun = 0, pos_ok = 0;
  int n = 0, cur_c = 0, cur_p = 0;
  int raw [COLS][ROWS][3];
  int eff [COLS][ROWS][3];

  matrix_scan_pwm #(.COLS(COLS), .ROWS(ROWS), .PWM_BITS(PB), .COL_CYCLES(CC),
                    .BLANK_CYCLES(BLANK), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
`ifdef MATRIX_BRIGHTNESS_EN
    .brightness  (PB'(bright)),
`endif
    .mem_data    (mem_data),
    .mem_addr    (mem_addr),
    .rgb         (rgb),
    .anode       (anode),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= ram[mem_addr];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snap(input int c);
    logic [PW-1:0] w;
    for (int r = 0; r < ROWS; r++) begin
      w = ram[c*ROWS + r];
      for (int ch = 0; ch < 3; ch++) raw[c][r][ch] = int'(w[ch*PB +: PB]);
    end
  endtask

  task automatic start();
    enable = 1'b1; mrun = 1; n = -1; pos_ok = 0;
    snap(0);
  endtask

  task automatic stop();
    enable = 1'b0; mrun = 0; pos_ok = 0;
  endtask

  // Model time n = edges since enable was sampled; display starts ROWS+2 edges later.
  task automatic tick();
    int exp_an, exp_rgb, exp_fs, exp_addr, s, c, u, p;
    @(posedge clk); #1;
    exp_an = 0; exp_rgb = 0; exp_fs = 0; exp_addr = 0; pos_ok = 0;
    if (mrun) begin
      n++;
      if (n < ROWS) exp_addr = n;
      else if (n > ROWS) begin
        s = (n-ROWS-1) % CC; c = ((n-ROWS-1) / CC) % COLS;
        if (s < ROWS) exp_addr = ((c+1) % COLS)*ROWS + s;
      end
      if (n >= ROWS+2) begin
        u = n-ROWS-2; p = u % CC; c = (u / CC) % COLS;
        if (p == 0) begin
          for (int r = 0; r < ROWS; r++)
            for (int ch = 0; ch < 3; ch++)
              eff[c][r][ch] = (raw[c][r][ch] * (bright+1)) >> PB;
          snap((c+1) % COLS);
        end
        if (p < DISP) begin
          exp_an = 1 << c;
          for (int r = 0; r < ROWS; r++)
            for (int ch = 0; ch < 3; ch++)
              if ((p % (1<<PB)) < eff[c][r][ch]) exp_rgb |= 1 << (3*r+ch);
        end
        exp_fs = (p == 0 && c == 0) ? 1 : 0;
        cur_c = c; cur_p = p; pos_ok = 1;
      end
    end
    chk("anode", int'(anode), exp_an);
    chk("rgb", int'(rgb), exp_rgb);
    chk("frame_start", int'(frame_start), exp_fs);
    chk("mem_addr", int'(mem_addr), exp_addr);
    chk("onehot", ($countones(anode) <= 1) ? 1 : 0, 1);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic run_until(input int c, input int p, input int budget);
    int k = 0;
    while (!(pos_ok && cur_c == c && cur_p == p) && k < budget) begin tick(); k++; end
    chk("reach_pos", (pos_ok && cur_c == c && cur_p == p) ? 1 : 0, 1);
  endtask

  task automatic run_rand(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (pos_ok && cur_p >= 5 && cur_p <= 30) begin
        if ($urandom_range(0, 7) == 0) ram[$urandom_range(0, COLS*ROWS-1)] = PW'($urandom);
`ifdef MATRIX_BRIGHTNESS_EN
        if ($urandom_range(0, 15) == 0) bright = int'($urandom_range(0, 15));
`endif
      end
      if (mrun && $urandom_range(0, 199) == 0) begin
        stop(); tick(); tick(); start();
      end
      tick();
    end
  endtask

  initial begin
    int fs, r2, gb, on, lo15, hi0;
    for (int i = 0; i < COLS*ROWS; i++) ram[i] = '0;
    #1;
    chk("rst_anode", int'(anode), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_fs", int'(frame_start), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    run(3);

    // single red pixel, duty 15
    ram[0] = 12'hF00;
    start();
    fs = 0; r2 = 0; gb = 0;
    for (int i = 0; i < CC*COLS + ROWS + 2; i++) begin
      tick();
      if (frame_start) fs++;
      if (anode == 4'b0001 && rgb[2]) r2++;
      if (rgb[1:0] != 2'b00) gb++;
    end
    chk("fs_once", fs, 1);
    chk("r15_on", r2, 30);
    chk("gb_dark", gb, 0);

    // all pixels duty 8, two frames of anode timing
    stop(); tick();
    for (int i = 0; i < COLS*ROWS; i++) ram[i] = 12'h888;
    start();
    on = 0;
    for (int i = 0; i < 2*CC*COLS + ROWS + 2; i++) begin
      tick();
      if (anode != '0) on++;
    end
    chk("anode_on", on, 2*COLS*DISP);

    // column 2 duty 0/15 pixels and a column 1 update ahead of its prefetch
    run_until(3, 10, 400);
    ram[4] = 12'h0F0;
    ram[5] = 12'hF0F;
    ram[2] = 12'h5A3;
    run_until(2, 0, 400);
    lo15 = 0; hi0 = 0;
    for (int i = 0; i < DISP; i++) begin
      if (i > 0) tick();
      if (!rgb[1]) lo15++;
      if (rgb[2]) hi0++;
    end
    chk("d15_low", lo15, DISP / 16);
    chk("d0_high", hi0, 0);
    // written while column 1 is on display: must wait a frame
    run_until(1, 10, 400);
    ram[2] = 12'h1C7;
    run(CC*COLS + 20);

    // disable mid-display, then re-prime
    run_until(2, 20, 400);
    stop(); tick();
    chk("dis_anode", int'(anode), 0);
    chk("dis_rgb", int'(rgb), 0);
    run(5);
    start();
    run_until(0, 0, 50);
    chk("restart_fs", int'(frame_start), 1);
    run(CC);

`ifdef MATRIX_BRIGHTNESS_EN
    stop(); tick();
    for (int i = 0; i < COLS*ROWS; i++) ram[i] = 12'hFFF;
    bright = 7;
    start();
    run_until(0, 0, 50);
    r2 = 0;
    for (int i = 0; i < DISP; i++) begin
      if (i > 0) tick();
      if (rgb[2]) r2++;
    end
    chk("bright7", r2, 14);
    bright = 15;
`endif

    for (int it = 0; it < 6; it++) begin
      stop(); tick();
      for (int i = 0; i < COLS*ROWS; i++) ram[i] = PW'($urandom);
      start();
      run_rand(400);
    end

    // asynchronous reset mid-display, mem_addr is nonzero at this point
    run_until(0, 0, 400);
    #2 rst = 1'b1;
    #1;
    chk("arst_anode", int'(anode), 0);
    chk("arst_rgb", int'(rgb), 0);
    chk("arst_addr", int'(mem_addr), 0);
    chk("arst_fs", int'(frame_start), 0);
    stop();
    #2 rst = 1'b0;
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
